// File: rtl/handshake_pkg.sv
// Shared types and constants for the handshake driver and its entry FIFO.
// Operand fields are sized for the widest supported word; the FIFO keeps only the WIDTH bits in use.
package handshake_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 32;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] in1;
        logic [MAX_WIDTH-1:0] in2;
        logic                 flag;
        logic                 result;
    } entry_t;

    localparam logic [7:0] STALL_MAX = 8'd255;

endpackage

// File: rtl/hs_fifo.sv
// Power-of-two entry FIFO with a combinational head so a freshly pushed entry is visible next cycle.
module hs_fifo
    import handshake_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 10,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; stale contents are never observed because valid gates the head.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/handshake_driver.sv
// Buffers operand requests and presents them one at a time on a round-robin selected
// downstream lane, holding each until that lane accepts it.
module handshake_driver
    import handshake_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LANES = 3,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_flag,
    output logic [LANES-1:0] handshake_arr_valid,
    input  logic [LANES-1:0] handshake_arr_ready,
    output logic [WIDTH-1:0] arr_2d_0,
    output logic [WIDTH-1:0] arr_2d_1,
    output logic             out,
    output logic [7:0]       stall_cnt
);

    localparam int DATA_W = 2 * WIDTH + 2;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int RR_W   = (LANES > 1) ? $clog2(LANES) : 1;

    state_t            state_reg;
    state_t            state_next;
    logic [RR_W-1:0]   rr_reg;
    logic [7:0]        stall_cnt_reg;
    logic              started_reg;

    logic              push;
    logic              accept;
    logic              presenting;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] push_word;
    logic [DATA_W-1:0] head_word;
    entry_t            head_entry;
    logic [2*MAX_WIDTH:0] unused_head_bits;

    // in_ready stays low through reset and rises on the first edge after release.
    assign in_ready   = started_reg && !fifo_full;
    assign push       = in_valid && in_ready;
    assign presenting = (state_reg == PRESENT);
    assign accept     = presenting && handshake_arr_ready[rr_reg];
    assign push_word  = {in1, in2, in_flag, (&in1) & in_flag};

    hs_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push        (push),
        .push_data   (push_word),
        .pop         (accept),
        .head_data   (head_word),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    always_comb begin
        head_entry                  = '0;
        head_entry.in1[WIDTH-1:0]   = head_word[DATA_W-1 -: WIDTH];
        head_entry.in2[WIDTH-1:0]   = head_word[2 +: WIDTH];
        head_entry.flag             = head_word[1];
        head_entry.result           = head_word[0];
    end

    assign unused_head_bits = {head_entry.in1, head_entry.in2, head_entry.flag};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (push) state_next = PRESENT;
            PRESENT: if (accept && (fifo_count == CW'(1)) && !push) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            stall_cnt_reg <= '0;
            started_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            started_reg <= 1'b1;
            if (accept) begin
                rr_reg <= (rr_reg == RR_W'(LANES - 1)) ? '0 : rr_reg + 1'b1;
            end
            if (!presenting || accept) begin
                stall_cnt_reg <= '0;
            end else if (stall_cnt_reg != STALL_MAX) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_valid
            assign handshake_arr_valid[gi] = presenting && (rr_reg == RR_W'(gi));
        end
    endgenerate

    // Payload is forced to zero while idle so unwritten storage never reaches the pins.
    assign arr_2d_0  = presenting ? head_entry.in1[WIDTH-1:0] : '0;
    assign arr_2d_1  = presenting ? head_entry.in2[WIDTH-1:0] : '0;
    assign out       = presenting && head_entry.result;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_handshake_driver.sv
// Directed self-checking bench for handshake_driver with default parameters.
module tb_handshake_driver;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;
    logic       in_flag = 1'b0;
    logic [2:0] handshake_arr_valid;
    logic [2:0] handshake_arr_ready = '0;
    logic [3:0] arr_2d_0;
    logic [3:0] arr_2d_1;
    logic       out;
    logic [7:0] stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    handshake_driver #(.DEPTH(4), .LANES(3), .WIDTH(4)) dut (
        .CLK                 (CLK),
        .ASYNCRESETN         (ASYNCRESETN),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in1                 (in1),
        .in2                 (in2),
        .in_flag             (in_flag),
        .handshake_arr_valid (handshake_arr_valid),
        .handshake_arr_ready (handshake_arr_ready),
        .arr_2d_0            (arr_2d_0),
        .arr_2d_1            (arr_2d_1),
        .out                 (out),
        .stall_cnt           (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Leaves the bench at a falling edge, one rising edge after release.
    task automatic apply_reset();
        @(negedge CLK);
        ASYNCRESETN = 1'b0;
        in_valid = 1'b0;
        handshake_arr_ready = '0;
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic f);
        in_valid = 1'b1; in1 = a; in2 = b; in_flag = f;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL rst_valid: got %b expected 000", handshake_arr_valid); else pass_cnt++;
        total_cnt++; if ({arr_2d_0, arr_2d_1, out} !== 9'h0) $display("FAIL rst_payload: got %h expected 000", {arr_2d_0, arr_2d_1, out}); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 8'd0) $display("FAIL rst_stall: got %0d expected 0", stall_cnt); else pass_cnt++;
        ASYNCRESETN = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_release_ready: got %b expected 0", in_ready); else pass_cnt++;
        @(negedge CLK);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready_rise: got %b expected 1", in_ready); else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        apply_reset();
        push_one(4'hF, 4'h3, 1'b1);
        total_cnt++; if (handshake_arr_valid !== 3'b001) $display("FAIL single_valid: got %b expected 001", handshake_arr_valid); else pass_cnt++;
        total_cnt++; if ({arr_2d_0, arr_2d_1, out} !== {4'hF, 4'h3, 1'b1}) $display("FAIL single_payload: got %h expected %h", {arr_2d_0, arr_2d_1, out}, {4'hF, 4'h3, 1'b1}); else pass_cnt++;
        handshake_arr_ready = 3'b001;
        @(negedge CLK);
        handshake_arr_ready = 3'b000;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL single_drained: got %b expected 000", handshake_arr_valid); else pass_cnt++;
        $display("test_single: transfer in1=F in2=3 out=1 on lane 0");
    endtask

    task automatic test_back_to_back();
        logic [3:0] v_in1  [4] = '{4'hF, 4'h1, 4'hF, 4'h7};
        logic [3:0] v_in2  [4] = '{4'h0, 4'h2, 4'h4, 4'h6};
        logic       v_flag [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       v_out  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] v_lane [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        apply_reset();
        for (int i = 0; i < 4; i++) push_one(v_in1[i], v_in2[i], v_flag[i]);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", in_ready); else pass_cnt++;
        handshake_arr_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({handshake_arr_valid, arr_2d_0, arr_2d_1, out} !== {v_lane[i], v_in1[i], v_in2[i], v_out[i]})
                $display("FAIL b2b_xfer%0d: got %h expected %h", i, {handshake_arr_valid, arr_2d_0, arr_2d_1, out}, {v_lane[i], v_in1[i], v_in2[i], v_out[i]});
            else pass_cnt++;
            $display("test_back_to_back: transfer %0d lane=%b in1=%h out=%b", i, handshake_arr_valid, arr_2d_0, out);
            @(negedge CLK);
        end
        handshake_arr_ready = 3'b000;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL b2b_idle: got %b expected 000", handshake_arr_valid); else pass_cnt++;
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_ready%0d: got %b expected 1", i, in_ready); else pass_cnt++;
            push_one(4'(i + 1), 4'(i), 1'b0);
        end
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_full: got %b expected 0", in_ready); else pass_cnt++;
        in_valid = 1'b1; in1 = 4'hA; in2 = 4'hA; in_flag = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        handshake_arr_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (arr_2d_0 !== 4'(i + 1)) $display("FAIL fill_drain%0d: got %h expected %h", i, arr_2d_0, 4'(i + 1)); else pass_cnt++;
            @(negedge CLK);
        end
        handshake_arr_ready = 3'b000;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL fill_fifth_dropped: got %b expected 000", handshake_arr_valid); else pass_cnt++;
        $display("test_fill: four entries stored, fifth refused");
    endtask

    task automatic test_backpressure();
        int bad_payload = 0;
        int bad_stall   = 0;
        int exp_stall;
        apply_reset();
        push_one(4'hF, 4'h5, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            if ({handshake_arr_valid, arr_2d_0, arr_2d_1, out} !== {3'b001, 4'hF, 4'h5, 1'b1}) bad_payload++;
            exp_stall = (k - 1 > 255) ? 255 : k - 1;
            if (stall_cnt !== 8'(exp_stall)) bad_stall++;
            if (k == 256) begin
                total_cnt++; if (stall_cnt !== 8'd255) $display("FAIL bp_stall_reach: got %0d expected 255", stall_cnt); else pass_cnt++;
            end
            if (k < 300) @(negedge CLK);
        end
        total_cnt++; if (bad_payload !== 0) $display("FAIL bp_payload_stable: got %0d unstable cycles expected 0", bad_payload); else pass_cnt++;
        total_cnt++; if (bad_stall !== 0) $display("FAIL bp_stall_track: got %0d wrong cycles expected 0", bad_stall); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 8'd255) $display("FAIL bp_stall_hold: got %0d expected 255", stall_cnt); else pass_cnt++;
        handshake_arr_ready = 3'b001;
        @(negedge CLK);
        handshake_arr_ready = 3'b000;
        total_cnt++; if (stall_cnt !== 8'd0) $display("FAIL bp_stall_clear: got %0d expected 0", stall_cnt); else pass_cnt++;
        $display("test_backpressure: 300 stalled cycles then accepted");
    endtask

    task automatic test_wrong_lane();
        apply_reset();
        push_one(4'h9, 4'h1, 1'b0);
        handshake_arr_ready = 3'b110;
        repeat (2) @(negedge CLK);
        total_cnt++; if (handshake_arr_valid !== 3'b001) $display("FAIL wrong_lane_hold: got %b expected 001", handshake_arr_valid); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 8'd2) $display("FAIL wrong_lane_stall: got %0d expected 2", stall_cnt); else pass_cnt++;
        handshake_arr_ready = 3'b001;
        @(negedge CLK);
        handshake_arr_ready = 3'b000;
        push_one(4'h2, 4'h8, 1'b1);
        total_cnt++; if ({handshake_arr_valid, arr_2d_0, arr_2d_1} !== {3'b010, 4'h2, 4'h8}) $display("FAIL wrong_lane_next: got %h expected %h", {handshake_arr_valid, arr_2d_0, arr_2d_1}, {3'b010, 4'h2, 4'h8}); else pass_cnt++;
        $display("test_wrong_lane: off-lane ready ignored");
    endtask

    task automatic test_push_pop();
        apply_reset();
        push_one(4'h2, 4'h0, 1'b0);
        handshake_arr_ready = 3'b111;
        push_one(4'h3, 4'hC, 1'b0);
        total_cnt++; if ({handshake_arr_valid, arr_2d_0, arr_2d_1} !== {3'b010, 4'h3, 4'hC}) $display("FAIL pushpop_next: got %h expected %h", {handshake_arr_valid, arr_2d_0, arr_2d_1}, {3'b010, 4'h3, 4'hC}); else pass_cnt++;
        @(negedge CLK);
        handshake_arr_ready = 3'b000;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL pushpop_empty: got %b expected 000", handshake_arr_valid); else pass_cnt++;
        $display("test_push_pop: simultaneous push and pop");
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) push_one(4'(i + 4), 4'(i), 1'b1);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        total_cnt++; if (handshake_arr_valid !== 3'b000) $display("FAIL async_valid: got %b expected 000", handshake_arr_valid); else pass_cnt++;
        total_cnt++; if ({in_ready, arr_2d_0, arr_2d_1, out} !== 10'h0) $display("FAIL async_outputs: got %h expected 000", {in_ready, arr_2d_0, arr_2d_1, out}); else pass_cnt++;
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        total_cnt++; if ({in_ready, handshake_arr_valid} !== 4'b1000) $display("FAIL async_empty: got %b expected 1000", {in_ready, handshake_arr_valid}); else pass_cnt++;
        push_one(4'hE, 4'h7, 1'b1);
        total_cnt++; if ({handshake_arr_valid, arr_2d_0, arr_2d_1} !== {3'b001, 4'hE, 4'h7}) $display("FAIL async_rr0: got %h expected %h", {handshake_arr_valid, arr_2d_0, arr_2d_1}, {3'b001, 4'hE, 4'h7}); else pass_cnt++;
        $display("test_async_reset: entries discarded, lane 0 restarts");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_backpressure();
        test_wrong_lane();
        test_push_pop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/handshake_driver.md
HANDSHAKE_DRIVER -- requirements
Module: handshake_driver

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter LANES, default 3, number of downstream handshake lanes.
REQ-003 Parameter WIDTH, default 4, width of each operand word.
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 ASYNCRESETN  in  1  reset, asynchronous and active-low.
REQ-006 in_valid  in  1  upstream request valid.
REQ-007 in_ready  out  1  upstream request accepted when high together with in_valid.
REQ-008 in1  in  WIDTH  operand word 1.
REQ-009 in2  in  WIDTH  operand word 2.
REQ-010 in_flag  in  1  qualifier bit (tuple element 0).
REQ-011 handshake_arr_valid  out  LANES  per-lane valid, one-hot or zero.
REQ-012 handshake_arr_ready  in  LANES  per-lane ready.
REQ-013 arr_2d_0, arr_2d_1  out  WIDTH each  payload words, shared by all lanes.
REQ-014 out  out  1  payload result bit, shared by all lanes.
REQ-015 stall_cnt  out  8  cycles the current head has been presented without acceptance.

Function
REQ-016 Enqueue on in_valid && in_ready; store {in1, in2, in_flag, result}, with result = (&in1) & in_flag computed at enqueue.
REQ-017 in_ready SHALL be (count < DEPTH), registered-state based; a same-cycle pop SHALL NOT raise in_ready; there is no bypass.
REQ-018 Control FSM: IDLE (FIFO empty, all valids 0) -> PRESENT (head driven on lane rr).
REQ-019 The FSM SHALL go IDLE->PRESENT on the cycle after the first enqueue; minimum latency, push to valid, is 1 cycle.
REQ-020 In PRESENT, handshake_arr_valid[rr]=1 and all other bits 0; arr_2d_0=in1, arr_2d_1=in2, out=result of the head entry.
REQ-021 Once asserted, valid, lane index, and payload SHALL hold stable until handshake_arr_ready[rr] is high.
REQ-022 Ready on a non-selected lane SHALL be ignored.
REQ-023 Acceptance pops the head and advances rr by 1 modulo LANES (LANES-1 wraps to 0).
REQ-024 After acceptance, the FSM stays in PRESENT if entries remain, so back-to-back transfers run at 1 per cycle; otherwise it goes to IDLE.
REQ-025 Simultaneous push and pop SHALL keep count unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-027 stall_cnt SHALL increment each PRESENT cycle without acceptance, saturate at 255, and clear to 0 on acceptance or in IDLE.

Reset
REQ-028 Asserting ASYNCRESETN low SHALL immediately, without waiting for a clock edge, clear count, pointers, rr=0, FSM=IDLE, stall_cnt=0, and handshake_arr_valid=0.
REQ-029 During reset, in_ready=0; arr_2d_0, arr_2d_1, and out=0.
REQ-030 in_ready SHALL rise on the first CLK edge after deassertion.
REQ-031 Reset during a transfer SHALL discard all stored entries.
REQ-032 Reset deassertion SHALL be synchronized externally; the block does not synchronize it.

Structure
REQ-033 Shared package handshake_pkg SHALL hold the FSM state enum (IDLE, PRESENT), the entry struct {in1, in2, flag, result}, and the STALL_MAX=255 constant.
REQ-034 One sub-module, hs_fifo (parameterized storage with push, pop, full, empty, and count), SHALL hold the entries; the FSM, rr, and stall counter live in the top.

Verification
REQ-035 Single push: in1=4'hF, in2=4'h3, in_flag=1 -> next cycle handshake_arr_valid=3'b001, arr_2d_0=F, arr_2d_1=3, out=1.
REQ-036 Four pushes with all lanes ready -> valids 001, 010, 100, 001 on consecutive cycles; result is 0 whenever in1!=F.
REQ-037 Fill: five pushes with lane ready held 0 -> in_ready=0 after the 4th push; the 5th is not accepted; count=4.
REQ-038 Backpressure for 300 cycles -> payload stable throughout; stall_cnt reaches 255 and holds; it clears the cycle after ready.
REQ-039 Ready asserted only on a non-selected lane (rr=0, ready=3'b110) -> no pop, valid stays 001.
REQ-040 ASYNCRESETN low mid-burst with 3 entries stored -> valids 0 immediately without a clock edge; after release, FIFO empty and rr=0.
